// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access width codes,
// FSM state encoding and the default bus timeout.
package lsu_pkg;

  localparam logic [2:0] LSU_W_B  = 3'b000;
  localparam logic [2:0] LSU_W_H  = 3'b001;
  localparam logic [2:0] LSU_W_W  = 3'b010;
  localparam logic [2:0] LSU_W_BU = 3'b100;
  localparam logic [2:0] LSU_W_HU = 3'b101;

  localparam int LSU_TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_DONE = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: strobes, write replication, legality and load extend.
// LSU_MISALIGN_TRAP_EN turns misaligned H/W accesses into faults instead of aligning.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_load,
  input  logic            i_store,
  input  logic [1:0]      i_addr_lo,
  input  logic [2:0]      i_width,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [1:0]      i_rsp_off,
  input  logic [2:0]      i_rsp_width,
  input  logic [XLEN-1:0] i_rsp_rdata,
  output logic [1:0]      o_off,
  output logic [3:0]      o_strb,
  output logic [XLEN-1:0] o_wdata,
  output logic            o_illegal,
  output logic [XLEN-1:0] o_ldata
);

  logic            w_mis;
  logic            w_trap;
  logic            w_mem;
  logic            w_bad_w;
  logic [1:0]      w_off;
  logic [XLEN-1:0] w_sh;

  always_comb begin
    w_mis = 1'b0;
    w_off = i_addr_lo;
    case (i_width[1:0])
      2'b01: begin
        w_mis = i_addr_lo[0];
        w_off = {i_addr_lo[1], 1'b0};
      end
      2'b10: begin
        w_mis = |i_addr_lo;
        w_off = 2'b00;
      end
      default: ;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_trap = w_mis;
`else
  assign w_trap = 1'b0;
`endif

  assign o_off   = w_off;
  assign w_mem   = i_load | i_store;
  assign w_bad_w = (i_width == 3'b011) || (i_width[2] && i_width[1]);

  // BU/HU only make sense for loads
  assign o_illegal = (i_load && i_store)
                   || (w_mem && w_bad_w)
                   || (i_store && i_width[2])
                   || (w_mem && w_trap);

  always_comb begin
    case (i_width[1:0])
      2'b00: begin
        o_strb  = 4'b0001 << w_off;
        o_wdata = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        o_strb  = 4'b0011 << w_off;
        o_wdata = {2{i_wdata[15:0]}};
      end
      default: begin
        o_strb  = 4'b1111;
        o_wdata = i_wdata;
      end
    endcase
  end

  assign w_sh = i_rsp_rdata >> {i_rsp_off, 3'b000};

  always_comb begin
    case (i_rsp_width[1:0])
      2'b00:
        o_ldata = {{24{~i_rsp_width[2] & w_sh[7]}}, w_sh[7:0]};
      2'b01:
        o_ldata = {{16{~i_rsp_width[2] & w_sh[15]}}, w_sh[15:0]};
      default:
        o_ldata = i_rsp_rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one aligned access at a time over a req/ack data bus.
// Build option LSU_MISALIGN_TRAP_EN (see lsu_align) faults misaligned accesses.
module lsu
  import lsu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = LSU_TIMEOUT_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            is_load,
  input  logic            is_store,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  input  logic [2:0]      data_width,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] rdata,
  output logic            err,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wstrb,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

  lsu_state_e      r_state;
  lsu_state_e      w_next;
  logic [XLEN-1:0] r_mem_addr;
  logic            r_mem_we;
  logic [XLEN-1:0] r_mem_wdata;
  logic [3:0]      r_mem_wstrb;
  logic [1:0]      r_off;
  logic [2:0]      r_width;
  logic [XLEN-1:0] r_rdata;
  logic            r_err;
  logic [31:0]     r_cnt;

  logic [1:0]      w_off;
  logic [3:0]      w_strb;
  logic [XLEN-1:0] w_wdata;
  logic            w_illegal;
  logic [XLEN-1:0] w_ldata;
  logic            w_mem_op;
  logic            w_tmo;

  lsu_align #(.XLEN(XLEN)) u_align (
    .i_load      (is_load),
    .i_store     (is_store),
    .i_addr_lo   (addr[1:0]),
    .i_width     (data_width),
    .i_wdata     (wdata),
    .i_rsp_off   (r_off),
    .i_rsp_width (r_width),
    .i_rsp_rdata (mem_rdata),
    .o_off       (w_off),
    .o_strb      (w_strb),
    .o_wdata     (w_wdata),
    .o_illegal   (w_illegal),
    .o_ldata     (w_ldata)
  );

  assign w_mem_op = (is_load | is_store) & ~w_illegal;
  assign w_tmo    = (TIMEOUT != 0) && (r_cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (rst) r_state <= LSU_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      LSU_IDLE:
        if (in_valid) w_next = w_mem_op ? LSU_REQ : LSU_DONE;
      LSU_REQ:
        if (mem_ack || w_tmo) w_next = LSU_DONE;
      LSU_DONE:
        if (out_ready) w_next = LSU_IDLE;
      default:
        w_next = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= 4'b0000;
      r_off       <= 2'b00;
      r_width     <= 3'b000;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        LSU_IDLE: begin
          r_cnt <= '0;
          if (in_valid) begin
            if (w_mem_op) begin
              r_mem_addr  <= {addr[XLEN-1:2], 2'b00};
              r_mem_we    <= is_store;
              r_mem_wdata <= is_store ? w_wdata : '0;
              r_mem_wstrb <= is_store ? w_strb : 4'b0000;
              r_off       <= w_off;
              r_width     <= data_width;
            end
            // pass-through returns addr; faults and bus ops start from 0
            r_rdata <= (is_load | is_store) ? '0 : addr;
            r_err   <= w_illegal;
          end
        end
        LSU_REQ: begin
          if (mem_ack) begin
            r_rdata <= r_mem_we ? '0 : w_ldata;
            r_err   <= 1'b0;
          end else if (w_tmo) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == LSU_IDLE);
  assign out_valid = (r_state == LSU_DONE);
  assign mem_req   = (r_state == LSU_REQ);
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wstrb = r_mem_wstrb;
  assign rdata     = r_rdata;
  assign err       = r_err;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: vector table for single accesses plus
// hand sequences for stalls, hold, timeout and reset.
module tb_lsu;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        is_load;
  logic        is_store;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  data_width;
  logic        out_ready;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        t_ack;

  logic        in_ready, out_valid, err, mem_req, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;

  logic        t_in_ready, t_out_valid, t_err, t_mem_req, t_mem_we;
  logic [31:0] t_rdata, t_mem_addr, t_mem_wdata;
  logic [3:0]  t_mem_wstrb;

  int checks;
  int failures;

  lsu dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .is_load(is_load), .is_store(is_store),
    .addr(addr), .wdata(wdata), .data_width(data_width),
    .out_valid(out_valid), .out_ready(out_ready),
    .rdata(rdata), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  lsu #(.TIMEOUT(4)) dut_t (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(t_in_ready),
    .is_load(is_load), .is_store(is_store),
    .addr(addr), .wdata(wdata), .data_width(data_width),
    .out_valid(t_out_valid), .out_ready(out_ready),
    .rdata(t_rdata), .err(t_err),
    .mem_req(t_mem_req), .mem_we(t_mem_we), .mem_addr(t_mem_addr),
    .mem_wdata(t_mem_wdata), .mem_wstrb(t_mem_wstrb),
    .mem_ack(t_ack), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  w;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] mrd;
    logic        bus;
    logic [31:0] eaddr;
    logic        ewe;
    logic [3:0]  estrb;
    logic [31:0] ewdata;
    logic [31:0] erd;
    logic        eerr;
  } vec_t;

  vec_t tv[14];

  function automatic vec_t mk(
    input logic ld, input logic st, input logic [2:0] w,
    input logic [31:0] a, input logic [31:0] wd, input logic [31:0] mrd,
    input logic bus, input logic [31:0] eaddr, input logic ewe,
    input logic [3:0] estrb, input logic [31:0] ewdata,
    input logic [31:0] erd, input logic eerr);
    vec_t v;
    v.ld = ld; v.st = st; v.w = w; v.a = a; v.wd = wd; v.mrd = mrd;
    v.bus = bus; v.eaddr = eaddr; v.ewe = ewe; v.estrb = estrb;
    v.ewdata = ewdata; v.erd = erd; v.eerr = eerr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ld, input logic st, input logic [2:0] w,
                       input logic [31:0] a, input logic [31:0] wd);
    in_valid = 1'b1;
    is_load = ld; is_store = st; data_width = w; addr = a; wdata = wd;
  endtask

  task automatic idle_in();
    in_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; in_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
    addr = '0; wdata = '0; data_width = 3'b000;
    out_ready = 1'b1; mem_ack = 1'b0; mem_rdata = '0; t_ack = 1'b0;

    tv[0]  = mk(1,0,3'b000,32'h1003,0,32'h80FF_1234,1,32'h1000,0,4'b0000,0,32'hFFFF_FF80,0);
    tv[1]  = mk(1,0,3'b101,32'h2002,0,32'hBEEF_0000,1,32'h2000,0,4'b0000,0,32'h0000_BEEF,0);
    tv[2]  = mk(0,1,3'b000,32'h3001,32'hAB,0,1,32'h3000,1,4'b0010,32'hABAB_ABAB,0,0);
    tv[3]  = mk(0,0,3'b010,32'h1234_5678,0,0,0,0,0,4'b0000,0,32'h1234_5678,0);
`ifdef LSU_MISALIGN_TRAP_EN
    tv[4]  = mk(1,0,3'b010,32'h4002,0,32'hDEAD_BEEF,0,0,0,4'b0000,0,0,1);
    tv[12] = mk(1,0,3'b001,32'h5001,0,32'h7FFF_8001,0,0,0,4'b0000,0,0,1);
`else
    tv[4]  = mk(1,0,3'b010,32'h4002,0,32'hDEAD_BEEF,1,32'h4000,0,4'b0000,0,32'hDEAD_BEEF,0);
    tv[12] = mk(1,0,3'b001,32'h5001,0,32'h7FFF_8001,1,32'h5000,0,4'b0000,0,32'hFFFF_8001,0);
`endif
    tv[5]  = mk(1,0,3'b001,32'h5000,0,32'h0000_8001,1,32'h5000,0,4'b0000,0,32'hFFFF_8001,0);
    tv[6]  = mk(0,1,3'b001,32'h6002,32'h1234_CAFE,0,1,32'h6000,1,4'b1100,32'hCAFE_CAFE,0,0);
    tv[7]  = mk(1,1,3'b010,32'h7000,0,0,0,0,0,4'b0000,0,0,1);
    tv[8]  = mk(0,1,3'b100,32'h7000,32'h55,0,0,0,0,4'b0000,0,0,1);
    tv[9]  = mk(1,0,3'b100,32'h7001,0,32'h0000_9A00,1,32'h7000,0,4'b0000,0,32'h0000_009A,0);
    tv[10] = mk(0,1,3'b010,32'h8000,32'h1122_3344,0,1,32'h8000,1,4'b1111,32'h1122_3344,0,0);
    tv[11] = mk(1,0,3'b011,32'h8000,0,0,0,0,0,4'b0000,0,0,1);
    tv[13] = mk(1,0,3'b000,32'h9002,0,32'h0045_0000,1,32'h9000,0,4'b0000,0,32'h0000_0045,0);

    tick(); tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_wstrb", mem_wstrb, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 14; i++) begin
      drive(tv[i].ld, tv[i].st, tv[i].w, tv[i].a, tv[i].wd);
      chk($sformatf("v%0d_in_ready", i), in_ready, 1);
      tick();
      idle_in();
      if (tv[i].bus) begin
        chk($sformatf("v%0d_req", i), mem_req, 1);
        chk($sformatf("v%0d_valid_early", i), out_valid, 0);
        chk($sformatf("v%0d_maddr", i), mem_addr, tv[i].eaddr);
        chk($sformatf("v%0d_we", i), mem_we, tv[i].ewe);
        chk($sformatf("v%0d_strb", i), mem_wstrb, tv[i].estrb);
        if (tv[i].ewe)
          chk($sformatf("v%0d_wdata", i), mem_wdata, tv[i].ewdata);
        mem_ack = 1'b1;
        mem_rdata = tv[i].mrd;
        tick();
        mem_ack = 1'b0;
      end
      chk($sformatf("v%0d_req_off", i), mem_req, 0);
      chk($sformatf("v%0d_valid", i), out_valid, 1);
      chk($sformatf("v%0d_rdata", i), rdata, tv[i].erd);
      chk($sformatf("v%0d_err", i), err, tv[i].eerr);
      tick();
      chk($sformatf("v%0d_valid_drop", i), out_valid, 0);
      chk($sformatf("v%0d_ready_back", i), in_ready, 1);
    end

    // store held off by the bus for five cycles
    drive(0, 1, 3'b010, 32'h3000, 32'hA5A5_5A5A);
    tick();
    idle_in();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("sw_stall%0d_req", k), mem_req, 1);
      chk($sformatf("sw_stall%0d_addr", k), mem_addr, 32'h3000);
      chk($sformatf("sw_stall%0d_strb", k), mem_wstrb, 4'b1111);
      chk($sformatf("sw_stall%0d_wdata", k), mem_wdata, 32'hA5A5_5A5A);
      chk($sformatf("sw_stall%0d_we", k), mem_we, 1);
      chk($sformatf("sw_stall%0d_valid", k), out_valid, 0);
      tick();
    end
    mem_ack = 1'b1;
    chk("sw_ack_req", mem_req, 1);
    tick();
    mem_ack = 1'b0;
    chk("sw_done_valid", out_valid, 1);
    chk("sw_done_err", err, 0);
    chk("sw_done_rdata", rdata, 0);
    chk("sw_done_req", mem_req, 0);
    tick();

    // result held while writeback stalls
    out_ready = 1'b0;
    drive(0, 0, 3'b000, 32'hCAFE_F00D, 0);
    tick();
    idle_in();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("hold%0d_valid", k), out_valid, 1);
      chk($sformatf("hold%0d_rdata", k), rdata, 32'hCAFE_F00D);
      chk($sformatf("hold%0d_in_ready", k), in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("hold_release", out_valid, 0);

    // timeout on the TIMEOUT=4 instance, no ack anywhere
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1, 0, 3'b010, 32'h0100, 0);
    tick();
    idle_in();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("tmo%0d_req", k), t_mem_req, 1);
      chk($sformatf("tmo%0d_valid", k), t_out_valid, 0);
      tick();
    end
    chk("tmo_req_off", t_mem_req, 0);
    chk("tmo_valid", t_out_valid, 1);
    chk("tmo_err", t_err, 1);
    chk("tmo_rdata", t_rdata, 0);

    // reset while the default instance is still requesting
    chk("rstreq_pre", mem_req, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstreq_req", mem_req, 0);
    chk("rstreq_in_ready", in_ready, 1);
    chk("rstreq_valid", out_valid, 0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("late_ack_valid", out_valid, 0);
    chk("late_ack_in_ready", in_ready, 1);
    chk("late_ack_req", mem_req, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
